// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips one command to the active area and streams one
// framebuffer write per clock in raster order.
module rect_fill_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = 11,
    parameter int PIX_W   = 8
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_w,
    input  logic [COORD_W-1:0] cmd_h,
    input  logic [PIX_W-1:0]   cmd_color,
    input  logic               abort,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [PIX_W-1:0]   pixel_GS,
    output logic               pixel_write,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CLIP = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_RES);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_RES);

    logic [1:0]         r_state;
    logic [COORD_W-1:0] r_x0, r_y0, r_w, r_h;
    logic [PIX_W-1:0]   r_color;
    logic [COORD_W:0]   r_x_end, r_y_end;
    logic               r_empty;
    logic [COORD_W-1:0] r_x, r_y;
    logic [PIX_W-1:0]   r_pix;
    logic               r_pw;
    logic               r_done;

    logic [COORD_W:0]   w_x_sum, w_y_sum, w_x_end, w_y_end;
    logic               w_empty, w_x_last, w_y_last;

    // One extra bit on the sums so x0+w never wraps before the clamp.
    assign w_x_sum  = {1'b0, r_x0} + {1'b0, r_w};
    assign w_y_sum  = {1'b0, r_y0} + {1'b0, r_h};
    assign w_x_end  = (w_x_sum > H_LIM) ? H_LIM : w_x_sum;
    assign w_y_end  = (w_y_sum > V_LIM) ? V_LIM : w_y_sum;
    assign w_empty  = (r_w == '0) || (r_h == '0) ||
                      ({1'b0, r_x0} >= H_LIM) || ({1'b0, r_y0} >= V_LIM);
    assign w_x_last = ({1'b0, r_x} == (r_x_end - 1'b1));
    assign w_y_last = ({1'b0, r_y} == (r_y_end - 1'b1));

    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign x           = r_x;
    assign y           = r_y;
    assign pixel_GS    = r_pix;
    assign pixel_write = r_pw;
    assign done        = r_done;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_color <= '0;
            r_x_end <= '0;
            r_y_end <= '0;
            r_empty <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_pix   <= '0;
            r_pw    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_x0    <= cmd_x0;
                        r_y0    <= cmd_y0;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_color <= cmd_color;
                        r_state <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (abort) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        // An empty command spends one silent fill slot so its
                        // done pulse lands two edges after the handshake.
                        r_empty <= w_empty;
                        r_state <= S_FILL;
                        if (!w_empty) begin
                            r_x_end <= w_x_end;
                            r_y_end <= w_y_end;
                            r_x     <= r_x0;
                            r_y     <= r_y0;
                            r_pix   <= r_color;
                            r_pw    <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (abort || r_empty) begin
                        r_state <= S_DONE;
                        r_pw    <= 1'b0;
                        r_done  <= 1'b1;
                        r_empty <= 1'b0;
                    end else if (w_x_last) begin
                        r_x <= r_x0;
                        if (w_y_last) begin
                            r_state <= S_DONE;
                            r_pw    <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_y <= r_y + 1'b1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
